// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc tile scheduler: FSM state encoding and the layer config bundle.
package qracc_pkg;

    localparam int QRACC_ADDR_W = 32;
    localparam int QRACC_TILE_W = 16;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_FETCH,
        TS_LOAD,
        TS_ISSUE,
        TS_WAIT,
        TS_SETTLE,
        TS_WRITE,
        TS_DONE
    } tile_sched_state_e;

    typedef struct packed {
        logic [QRACC_TILE_W-1:0] num_tiles;
        logic [QRACC_ADDR_W-1:0] rd_base;
        logic [QRACC_ADDR_W-1:0] rd_stride;
        logic [QRACC_ADDR_W-1:0] wr_base;
        logic [QRACC_ADDR_W-1:0] wr_stride;
    } tile_sched_cfg_t;

endpackage

// File: rtl/qracc_tile_addr_gen.sv
// Base + k*stride address accumulator; load captures base/stride, step advances by stride.
module qracc_tile_addr_gen
#(
    parameter int addrWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 step,
    input  logic [addrWidth-1:0] base,
    input  logic [addrWidth-1:0] stride,
    output logic [addrWidth-1:0] addr
);

    logic [addrWidth-1:0] stride_q;

    // Sum wraps modulo 2^addrWidth by construction.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            addr <= addr + stride_q;
        end
    end

endmodule

// File: rtl/qracc_tile_scheduler.sv
// Per-layer tile sequencer: fetch/load rows, MAC handshake, scaler settle, writeback.
// Optional perf counters enabled by defining QRACC_TILE_PERF_EN.
module qracc_tile_scheduler
    import qracc_pkg::*;
#(
    parameter int addrWidth     = QRACC_ADDR_W,
    parameter int tileCountBits = QRACC_TILE_W,
    parameter int loadsPerTile  = 1,
    parameter int scalerLatency = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [tileCountBits-1:0] num_tiles_i,
    input  logic [addrWidth-1:0]     rd_base_i,
    input  logic [addrWidth-1:0]     rd_stride_i,
    input  logic [addrWidth-1:0]     wr_base_i,
    input  logic [addrWidth-1:0]     wr_stride_i,
    output logic                     buf_rd_en_o,
    output logic [addrWidth-1:0]     buf_rd_addr_o,
    output logic                     fl_wr_en_o,
    output logic [addrWidth-1:0]     fl_addr_o,
    output logic                     mac_valid_o,
    input  logic                     qracc_ready_i,
    input  logic                     qracc_valid_i,
    output logic                     buf_wr_en_o,
    output logic [addrWidth-1:0]     buf_wr_addr_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef QRACC_TILE_PERF_EN
    ,
    output logic [31:0]              perf_busy_cycles_o,
    output logic [31:0]              perf_stall_cycles_o
`endif
);

    localparam int LW = (loadsPerTile > 1) ? $clog2(loadsPerTile) : 1;
    localparam int SW = (scalerLatency > 1) ? $clog2(scalerLatency) : 1;

    tile_sched_state_e          state;
    tile_sched_cfg_t            cfg_in;
    logic [tileCountBits-1:0]   num_tiles_q;
    logic [tileCountBits-1:0]   tile;
    logic [tileCountBits-1:0]   tile_next;
    logic [LW-1:0]              load_idx;
    logic [SW-1:0]              settle_cnt;
    logic                       start_ok;

    always_comb begin
        cfg_in           = '0;
        cfg_in.num_tiles = QRACC_TILE_W'(num_tiles_i);
        cfg_in.rd_base   = QRACC_ADDR_W'(rd_base_i);
        cfg_in.rd_stride = QRACC_ADDR_W'(rd_stride_i);
        cfg_in.wr_base   = QRACC_ADDR_W'(wr_base_i);
        cfg_in.wr_stride = QRACC_ADDR_W'(wr_stride_i);
    end

    assign start_ok    = (state == TS_IDLE) && start_i;
    assign tile_next   = tile + 1'b1;
    // Issue is gated by ready in the same cycle so seq_acc never sees an unaccepted request.
    assign mac_valid_o = (state == TS_ISSUE) && qracc_ready_i;

    qracc_tile_addr_gen #(.addrWidth(addrWidth)) u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_i),
        .load   (start_ok),
        .step   (state == TS_FETCH),
        .base   (addrWidth'(cfg_in.rd_base)),
        .stride (addrWidth'(cfg_in.rd_stride)),
        .addr   (buf_rd_addr_o)
    );

    qracc_tile_addr_gen #(.addrWidth(addrWidth)) u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_i),
        .load   (start_ok),
        .step   (state == TS_WRITE),
        .base   (addrWidth'(cfg_in.wr_base)),
        .stride (addrWidth'(cfg_in.wr_stride)),
        .addr   (buf_wr_addr_o)
    );

    // Strobes are registered: each is raised on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state       <= TS_IDLE;
            num_tiles_q <= '0;
            tile        <= '0;
            load_idx    <= '0;
            settle_cnt  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            buf_rd_en_o <= 1'b0;
            fl_wr_en_o  <= 1'b0;
            fl_addr_o   <= '0;
            buf_wr_en_o <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            buf_rd_en_o <= 1'b0;
            fl_wr_en_o  <= 1'b0;
            fl_addr_o   <= '0;
            buf_wr_en_o <= 1'b0;
            case (state)
                TS_IDLE: begin
                    if (start_i) begin
                        num_tiles_q <= tileCountBits'(cfg_in.num_tiles);
                        tile        <= '0;
                        load_idx    <= '0;
                        busy_o      <= 1'b1;
                        if (cfg_in.num_tiles == '0) begin
                            state  <= TS_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= TS_FETCH;
                            buf_rd_en_o <= 1'b1;
                        end
                    end
                end
                TS_FETCH: begin
                    state      <= TS_LOAD;
                    fl_wr_en_o <= 1'b1;
                    fl_addr_o  <= addrWidth'(load_idx);
                end
                TS_LOAD: begin
                    if (int'(load_idx) == loadsPerTile - 1) begin
                        load_idx <= '0;
                        state    <= TS_ISSUE;
                    end else begin
                        load_idx    <= load_idx + 1'b1;
                        state       <= TS_FETCH;
                        buf_rd_en_o <= 1'b1;
                    end
                end
                TS_ISSUE: begin
                    if (qracc_ready_i) state <= TS_WAIT;
                end
                TS_WAIT: begin
                    if (qracc_valid_i) begin
                        settle_cnt <= '0;
                        if (scalerLatency == 0) begin
                            state       <= TS_WRITE;
                            buf_wr_en_o <= 1'b1;
                        end else begin
                            state <= TS_SETTLE;
                        end
                    end
                end
                TS_SETTLE: begin
                    if (int'(settle_cnt) >= scalerLatency - 1) begin
                        state       <= TS_WRITE;
                        buf_wr_en_o <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                TS_WRITE: begin
                    tile <= tile_next;
                    if (tile_next == num_tiles_q) begin
                        state  <= TS_DONE;
                        done_o <= 1'b1;
                    end else begin
                        state       <= TS_FETCH;
                        buf_rd_en_o <= 1'b1;
                    end
                end
                TS_DONE: begin
                    state  <= TS_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= TS_IDLE;
            endcase
        end
    end

`ifdef QRACC_TILE_PERF_EN
    // Saturating counters, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || clear_i || start_ok) begin
            perf_busy_cycles_o  <= '0;
            perf_stall_cycles_o <= '0;
        end else begin
            if (busy_o && (perf_busy_cycles_o != '1))
                perf_busy_cycles_o <= perf_busy_cycles_o + 1'b1;
            if (((state == TS_ISSUE && !qracc_ready_i) || state == TS_WAIT) &&
                (perf_stall_cycles_o != '1))
                perf_stall_cycles_o <= perf_stall_cycles_o + 1'b1;
        end
    end
`endif

endmodule
